led_pwm_ctrl: RTL

LED_PWM_CTRL -- requirements
Module: led_pwm_ctrl

---
 rtl/led_pwm_pkg.sv | 29 ++
 rtl/pwm_timebase.sv | 28 ++
 rtl/led_pwm_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/led_pwm_pkg.sv
// Shared register map, field positions and state encoding for the RGB LED PWM controller.
package led_pwm_pkg;

  localparam logic [31:0] OFS_CTRL  = 32'h0;
  localparam logic [31:0] OFS_PRESC = 32'h4;
  localparam logic [31:0] OFS_DUTY  = 32'h8;
  localparam logic [31:0] OFS_BLINK = 32'hC;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_BLINK_BIT = 1;
  localparam int CTRL_STATE_LSB = 4;

  localparam int DUTY_R_LSB = 0;
  localparam int DUTY_G_LSB = 8;
  localparam int DUTY_B_LSB = 16;

  localparam int BLINK_ON_LSB  = 0;
  localparam int BLINK_OFF_LSB = 8;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_DARK = 2'd2;

  // A period count of zero behaves like one so blinking never stalls.
  function automatic logic [8:0] at_least_one(input logic [7:0] v);
    return (v == 8'd0) ? 9'd1 : {1'b0, v};
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Prescaler plus 8-bit PWM step counter; clr holds both counters at zero.
module pwm_timebase (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic [15:0] presc,
  output logic        tick,
  output logic [7:0]  pwm_cnt,
  output logic        period_end
);

  logic [15:0] presc_cnt;

  // Compare against the current presc register, so a same-cycle rewrite only affects later ticks.
  assign tick       = !clr && (presc_cnt == presc);
  assign period_end = tick && (pwm_cnt == 8'hff);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      presc_cnt <= '0;
      pwm_cnt   <= '0;
    end else begin
      presc_cnt <= tick ? 16'd0 : presc_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Memory-mapped RGB LED PWM controller with shadowed duty and on/dark blink sequencing.
//   state | meaning
//   OFF   | disabled, counters held at zero, LEDs low
//   ON    | PWM driving LEDs, counting on-periods when blinking
//   DARK  | LEDs low, counting off-periods before returning to ON
//   (encoding 3 is unused and decodes to OFF)
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hffff0050
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b
);

  logic        en, blink_en;
  logic [15:0] presc;
  logic [23:0] duty_shadow, duty_act;
  logic [7:0]  on_periods, off_periods;
  logic [1:0]  state, state_dec, state_nxt;
  logic [7:0]  blink_cnt, blink_cnt_nxt;
  logic        load_duty, lit;
  logic        tick_unused, period_end;
  logic [7:0]  pwm_cnt;
  logic        hit_ctrl, hit_presc, hit_duty, hit_blink, rd_hit;
  logic [31:0] rd_data;

  assign hit_ctrl  = (mem_addr == BASE_ADDR + OFS_CTRL);
  assign hit_presc = (mem_addr == BASE_ADDR + OFS_PRESC);
  assign hit_duty  = (mem_addr == BASE_ADDR + OFS_DUTY);
  assign hit_blink = (mem_addr == BASE_ADDR + OFS_BLINK);

  assign state_dec = (state == ST_ON || state == ST_DARK) ? state : ST_OFF;

  pwm_timebase u_timebase (
    .clk        (clk),
    .rst        (rst),
    .clr        (state_dec == ST_OFF),
    .presc      (presc),
    .tick       (tick_unused),
    .pwm_cnt    (pwm_cnt),
    .period_end (period_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      en          <= 1'b0;
      blink_en    <= 1'b0;
      presc       <= '0;
      duty_shadow <= '0;
      on_periods  <= '0;
      off_periods <= '0;
    end else if (mem_we) begin
      if (hit_ctrl) begin
        en       <= mem_data[CTRL_EN_BIT];
        blink_en <= mem_data[CTRL_BLINK_BIT];
      end
      if (hit_presc) presc <= mem_data[15:0];
      if (hit_duty) duty_shadow <= mem_data[23:0];
      if (hit_blink) begin
        on_periods  <= mem_data[BLINK_ON_LSB +: 8];
        off_periods <= mem_data[BLINK_OFF_LSB +: 8];
      end
    end
  end

  always_comb begin
    state_nxt     = state_dec;
    blink_cnt_nxt = blink_cnt;
    load_duty     = period_end;
    case (state_dec)
      ST_ON: begin
        if (!blink_en) begin
          blink_cnt_nxt = '0;
        end else if (period_end) begin
          if (9'(blink_cnt) + 9'd1 >= at_least_one(on_periods)) begin
            state_nxt     = ST_DARK;
            blink_cnt_nxt = '0;
          end else begin
            blink_cnt_nxt = blink_cnt + 8'd1;
          end
        end
      end
      ST_DARK: begin
        if (period_end) begin
          if (!blink_en || (9'(blink_cnt) + 9'd1 >= at_least_one(off_periods))) begin
            state_nxt     = ST_ON;
            blink_cnt_nxt = '0;
          end else begin
            blink_cnt_nxt = blink_cnt + 8'd1;
          end
        end
      end
      default: begin
        blink_cnt_nxt = '0;
        if (en) begin
          state_nxt = ST_ON;
          load_duty = 1'b1;
        end
      end
    endcase
    if (!en) begin
      state_nxt     = ST_OFF;
      blink_cnt_nxt = '0;
    end
  end

  // Gating with en blanks the LEDs on the same edge the FSM falls back to OFF.
  assign lit = en && (state_dec == ST_ON);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      blink_cnt <= '0;
      duty_act  <= '0;
      led_r     <= 1'b0;
      led_g     <= 1'b0;
      led_b     <= 1'b0;
    end else begin
      state     <= state_nxt;
      blink_cnt <= blink_cnt_nxt;
      if (load_duty) duty_act <= duty_shadow;
      led_r <= lit && (pwm_cnt < duty_act[DUTY_R_LSB +: 8]);
      led_g <= lit && (pwm_cnt < duty_act[DUTY_G_LSB +: 8]);
      led_b <= lit && (pwm_cnt < duty_act[DUTY_B_LSB +: 8]);
    end
  end

  always_comb begin
    rd_data = '0;
    rd_hit  = 1'b1;
    if (hit_ctrl)       rd_data = {26'd0, state_dec, 2'b00, blink_en, en};
    else if (hit_presc) rd_data = {16'd0, presc};
    else if (hit_duty)  rd_data = {8'd0, duty_shadow};
    else if (hit_blink) rd_data = {16'd0, off_periods, on_periods};
    else                rd_hit  = 1'b0;
  end

  assign mem_data = (rd_hit && !mem_we && !rst) ? rd_data : 32'bz;

endmodule
